// File: rtl/cordic_vector.sv
// Shared atan(2^-i) table, radians Q3.16, indexed by micro-rotation step.
// Latency: combinational.
// Backpressure: none; pure lookup.
module cordic_atan_lut (
  input  logic        [3:0]  index,
  output logic signed [18:0] return_angle
);

  always_comb begin
    case (index)
      4'd0:    return_angle = 19'sd51472;
      4'd1:    return_angle = 19'sd30386;
      4'd2:    return_angle = 19'sd16055;
      4'd3:    return_angle = 19'sd8150;
      4'd4:    return_angle = 19'sd4091;
      4'd5:    return_angle = 19'sd2047;
      4'd6:    return_angle = 19'sd1024;
      4'd7:    return_angle = 19'sd512;
      4'd8:    return_angle = 19'sd256;
      4'd9:    return_angle = 19'sd128;
      4'd10:   return_angle = 19'sd64;
      4'd11:   return_angle = 19'sd32;
      4'd12:   return_angle = 19'sd16;
      4'd13:   return_angle = 19'sd8;
      4'd14:   return_angle = 19'sd4;
      default: return_angle = 19'sd2;
    endcase
  end

endmodule

// Iterative vectoring CORDIC: (x,y) -> atan2 angle and magnitude.
// Latency: ITER+1 cycles from accepted start to done; one vector per ITER+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module cordic_vector #(
  parameter int ITER      = 16,
  parameter int GAIN_COMP = 1
) (
  input  logic               clock,
  input  logic               init,
  input  logic               start,
  input  logic        [17:0] x_in,
  input  logic        [17:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [18:0] angle_out,
  output logic        [20:0] mag_out
);

  typedef enum logic [1:0] {IDLE, ROT, SCALE} state_t;

  localparam logic signed [18:0] HALF_PI = 19'sd102944;
  localparam logic signed [41:0] K_INV   = 42'sd39797;
  localparam logic        [3:0]  LAST    = 4'(ITER - 1);

  state_t state, state_nx;
  logic signed [20:0] x, y, x_nx, y_nx;
  logic signed [20:0] x_ext, y_ext, x_sh, y_sh;
  logic signed [18:0] z, z_nx, atan_i;
  logic        [3:0]  count, count_nx;
  logic               is_zero, is_zero_nx;
  logic               busy_nx, done_nx;
  logic signed [18:0] angle_nx;
  logic        [20:0] mag_nx;
  logic signed [41:0] x_wide, prod;

  cordic_atan_lut u_lut (
    .index        (count),
    .return_angle (atan_i)
  );

  assign x_ext  = {{3{x_in[17]}}, x_in};
  assign y_ext  = {{3{y_in[17]}}, y_in};
  assign x_sh   = x >>> count;
  assign y_sh   = y >>> count;
  assign x_wide = {{21{x[20]}}, x};
  assign prod   = x_wide * K_INV;

  always_comb begin
    state_nx   = state;
    x_nx       = x;
    y_nx       = y;
    z_nx       = z;
    count_nx   = count;
    is_zero_nx = is_zero;
    busy_nx    = busy;
    done_nx    = 1'b0;
    angle_nx   = angle_out;
    mag_nx     = mag_out;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = ROT;
          count_nx   = '0;
          busy_nx    = 1'b1;
          is_zero_nx = (x_ext == '0) && (y_ext == '0);
          // Fold left-half-plane vectors by +/-90 deg so the iterations converge.
          if (!x_ext[20]) begin
            x_nx = x_ext;
            y_nx = y_ext;
            z_nx = '0;
          end else if (!y_ext[20]) begin
            x_nx = y_ext;
            y_nx = -x_ext;
            z_nx = HALF_PI;
          end else begin
            x_nx = -y_ext;
            y_nx = x_ext;
            z_nx = -HALF_PI;
          end
        end
      end
      ROT: begin
        if (!y[20]) begin
          x_nx = x + y_sh;
          y_nx = y - x_sh;
          z_nx = z + atan_i;
        end else begin
          x_nx = x - y_sh;
          y_nx = y + x_sh;
          z_nx = z - atan_i;
        end
        count_nx = count + 4'd1;
        if (count == LAST) state_nx = SCALE;
      end
      SCALE: begin
        // A zero vector never drives y negative, so z would just sum the table.
        angle_nx = is_zero ? '0 : z;
        mag_nx   = (GAIN_COMP != 0) ? 21'(prod >>> 16) : x;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (init) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      count     <= '0;
      is_zero   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      state     <= state_nx;
      x         <= x_nx;
      y         <= y_nx;
      z         <= z_nx;
      count     <= count_nx;
      is_zero   <= is_zero_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      angle_out <= angle_nx;
      mag_out   <= mag_nx;
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed boundary vectors, timing, reset abort and random vectors
// against a real-arithmetic atan2/sqrt model.
module tb_cordic_vector;

  logic               clock = 1'b0;
  logic               init;
  logic               start;
  logic        [17:0] x_in;
  logic        [17:0] y_in;
  logic               busy, done, busy_raw, done_raw;
  logic signed [18:0] angle_out, angle_raw;
  logic        [20:0] mag_out, mag_raw;

  int checks   = 0;
  int failures = 0;

  localparam real CORDIC_K = 1.646760258;

  always #5 clock = ~clock;

  cordic_vector #(.ITER(16), .GAIN_COMP(1)) dut (
    .clock     (clock),
    .init      (init),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  cordic_vector #(.ITER(16), .GAIN_COMP(0)) dut_raw (
    .clock     (clock),
    .init      (init),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy_raw),
    .done      (done_raw),
    .angle_out (angle_raw),
    .mag_out   (mag_raw)
  );

  // Issues one request, scrambles the inputs afterwards, and waits (bounded) for done.
  task automatic run_vector(input int xv, input int yv, output int ang, output int mag,
                            output int magr, output int lat, output logic busy0,
                            output logic tmo);
    @(negedge clock);
    x_in  = 18'(xv);
    y_in  = 18'(yv);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    busy0 = busy;
    x_in  = 18'($urandom);
    y_in  = 18'($urandom);
    lat   = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    tmo  = (done !== 1'b1);
    ang  = int'(angle_out);
    mag  = int'(mag_out);
    magr = int'(mag_raw);
  endtask

  task automatic test_reset();
    init  = 1'b1;
    start = 1'b1;
    x_in  = 18'h10000;
    y_in  = 18'h10000;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (angle_out !== 19'sd0 || mag_out !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs angle=%0d mag=%0d expected 0 0", angle_out, mag_out);
    end
    start = 1'b0;
    @(negedge clock);
    init = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    int tx[7] = '{65536, 65536,     0, -65536,  -65536, 0, -131072};
    int ty[7] = '{    0, 65536, 65536,      0,  -65536, 0, -131072};
    int ta[7] = '{    0, 51472, 102944, 205887, -154415, 0, -154415};
    int tm[7] = '{65536, 92682, 65536,  65536,   92682, 0, 185364};
    int ang, mag, magr, lat, tol, d;
    logic busy0, tmo;
    for (int i = 0; i < 7; i++) begin
      run_vector(tx[i], ty[i], ang, mag, magr, lat, busy0, tmo);
      tol = (tx[i] == 0 && ty[i] == 0) ? 0 : 8;
      checks++;
      if (tmo) begin
        failures++;
        $display("FAIL dir_timeout vec=%0d no done within 40 cycles", i);
      end
      d = ang - ta[i];
      checks++;
      if (d < -tol || d > tol) begin
        failures++;
        $display("FAIL dir_angle vec=%0d got=%0d expected=%0d+/-%0d", i, ang, ta[i], tol);
      end
      d = mag - tm[i];
      checks++;
      if (d < -tol || d > tol) begin
        failures++;
        $display("FAIL dir_mag vec=%0d got=%0d expected=%0d+/-%0d", i, mag, tm[i], tol);
      end
      if (i == 0) begin
        checks++;
        if (lat != 17) begin
          failures++;
          $display("FAIL latency got=%0d cycles expected=17", lat);
        end
        checks++;
        if (busy0 !== 1'b1) begin
          failures++;
          $display("FAIL busy_after_start got=%b expected=1", busy0);
        end
      end
      if (i == 3) begin
        checks++;
        if (ang <= 0) begin
          failures++;
          $display("FAIL neg_x_angle_sign got=%0d expected positive (+pi)", ang);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n_done = 0;
    logic bad_done = 1'b0;
    logic bad_busy = 1'b0;
    logic exp_done;
    @(negedge clock);
    x_in  = 18'h08000;
    y_in  = 18'h38000;
    start = 1'b1;
    for (int n = 0; n < 54; n++) begin
      @(negedge clock);
      exp_done = (n == 17) || (n == 35) || (n == 53);
      if (done === 1'b1) n_done++;
      if (done !== exp_done) bad_done = 1'b1;
      if (busy !== !exp_done) bad_busy = 1'b1;
      if (n == 53) start = 1'b0;
    end
    checks++;
    if (n_done != 3) begin
      failures++;
      $display("FAIL held_start_done_count got=%0d expected=3", n_done);
    end
    checks++;
    if (bad_done) begin
      failures++;
      $display("FAIL held_start_done_timing got=irregular expected=one pulse per 18 cycles");
    end
    checks++;
    if (bad_busy) begin
      failures++;
      $display("FAIL held_start_busy got=irregular expected=busy except in done cycle");
    end
  endtask

  task automatic test_init_abort();
    int   ang, mag, magr, lat, d;
    logic busy0, tmo;
    logic saw_done = 1'b0;
    @(negedge clock);
    x_in  = 18'h0C000;
    y_in  = 18'h3A000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    init = 1'b1;
    @(negedge clock);
    init = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (angle_out !== 19'sd0 || mag_out !== 21'd0) begin
      failures++;
      $display("FAIL abort_outputs angle=%0d mag=%0d expected 0 0", angle_out, mag_out);
    end
    repeat (25) begin
      @(negedge clock);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_no_done got=done pulse expected=none");
    end
    run_vector(65536, -65536, ang, mag, magr, lat, busy0, tmo);
    checks++;
    if (tmo || lat != 17) begin
      failures++;
      $display("FAIL abort_restart_latency got=%0d timeout=%b expected=17", lat, tmo);
    end
    d = ang + 51472;
    checks++;
    if (d < -8 || d > 8) begin
      failures++;
      $display("FAIL abort_restart_angle got=%0d expected=-51472+/-8", ang);
    end
  endtask

  task automatic test_random();
    int     xv, yv, ang, mag, magr, lat;
    logic   busy0, tmo;
    longint r2;
    real    ea, em, er, da;
    for (int i = 0; i < 1000; i++) begin
      do begin
        xv = int'($urandom_range(262143, 0)) - 131072;
        yv = int'($urandom_range(262143, 0)) - 131072;
        r2 = longint'(xv) * xv + longint'(yv) * yv;
      end while (r2 < 64'sd4294967296);
      run_vector(xv, yv, ang, mag, magr, lat, busy0, tmo);
      ea = $atan2(real'(yv), real'(xv)) * 65536.0;
      em = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      er = em * CORDIC_K;
      checks++;
      if (tmo || lat != 17) begin
        failures++;
        $display("FAIL rand_latency x=%0d y=%0d got=%0d expected=17", xv, yv, lat);
      end
      da = real'(ang) - ea;
      checks++;
      if (da > 8.0 || da < -8.0) begin
        failures++;
        $display("FAIL rand_angle x=%0d y=%0d got=%0d expected=%0.1f+/-8", xv, yv, ang, ea);
      end
      da = real'(mag) - em;
      checks++;
      if (da > 8.0 || da < -8.0) begin
        failures++;
        $display("FAIL rand_mag x=%0d y=%0d got=%0d expected=%0.1f+/-8", xv, yv, mag, em);
      end
      da = real'(magr) - er;
      checks++;
      if (da > 16.0 || da < -16.0) begin
        failures++;
        $display("FAIL rand_raw_mag x=%0d y=%0d got=%0d expected=%0.1f+/-16", xv, yv, magr, er);
      end
    end
  endtask

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    init  = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_init_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
